sobol_sequencer: RTL and testbench
==================================

SOBOL_SEQUENCER -- requirements
Module: sobol_sequencer

Interface
REQ-001 SHALL have parameter M, default 12, meaning Sobol dimensions per point.
REQ-002 SHALL have localparam DIM_W, default $clog2(M), meaning dimension-select width.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a run; sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  cancel the current run.
REQ-007 SHALL have port n_start  input  32  first Sobol index, captured on accepted start.
REQ-008 SHALL have port n_count  input  32  number of points, captured on accepted start.
REQ-009 SHALL have port busy  output  1  high in RUN and FLUSH.
REQ-010 SHALL have port done  output  1  one-cycle pulse at normal completion.
REQ-011 SHALL have port out_valid  output  1  output beat valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts beat.
REQ-013 SHALL have port out_data  output  32  Sobol value for (out_index, out_dim).
REQ-014 SHALL have port out_index  output  32  Sobol index N of the beat.
REQ-015 SHALL have port out_dim  output  DIM_W  dimension of the beat.
REQ-016 SHALL have port out_last  output  1  high on the final beat of the run.

Function
REQ-017 SHALL implement states IDLE, RUN, FLUSH, DONE.
REQ-018 IDLE: start with n_count!=0 SHALL capture idx=n_start, dim=0, remaining=n_count, and enter RUN.
REQ-019 IDLE: start with n_count==0 SHALL enter DONE without emitting beats.
REQ-020 RUN SHALL drive the internal generator with (idx, dim) every cycle.
REQ-021 load = !out_valid || out_ready; on load in RUN, out_data/out_index/out_dim/out_last SHALL register the generator output and current idx/dim, and out_valid SHALL be set.
REQ-022 Each load SHALL increment dim; at dim==M-1, dim SHALL wrap to 0, idx SHALL increment modulo 2^32, and remaining SHALL decrement.
REQ-023 The load with dim==M-1 and remaining==1 SHALL set out_last and move RUN->FLUSH.
REQ-024 Output registers SHALL hold stable while out_valid && !out_ready.
REQ-025 FLUSH: out_valid && out_ready SHALL clear out_valid and enter DONE.
REQ-026 In RUN, out_valid && out_ready with no pending load SHALL clear out_valid; with a load in the same cycle, the new beat SHALL replace the old one with no bubble.
REQ-027 DONE SHALL assert done for exactly one cycle and return to IDLE.
REQ-028 First out_valid SHALL rise one cycle after accepted start; with out_ready held high, throughput SHALL be one beat per cycle; total beats SHALL be n_count*M.
REQ-029 start outside IDLE SHALL be ignored.
REQ-030 abort in any state SHALL clear out_valid and out_last, return to IDLE next cycle, and leave done low.
REQ-031 abort and start in the same IDLE cycle SHALL make abort win, with no run started.

Reset
REQ-032 rst SHALL force IDLE, busy=0, done=0, out_valid=0, out_last=0, out_data=0, out_index=0, out_dim=0, idx=0, dim=0, remaining=0.
REQ-033 rst mid-run SHALL discard the pending beat with no done pulse; rst SHALL take priority over abort and start.

Structure
REQ-034 The state enum and default M SHALL reside in a shared package sobol_pkg.
REQ-035 The block SHALL instantiate exactly one combinational sobol generator sub-module (sobol, parameter M) as its datapath.

Verification
REQ-036 n_start=10, n_count=2, out_ready=1 -> 24 consecutive beats, indices 10 then 11, dims 0..11 each, out_data matching the golden sobol model, out_last on beat 24, done one cycle after the last handshake.
REQ-037 Same run with out_ready toggling 1,0,0,1 -> beats stable while stalled, no loss or duplication, same 24-beat sequence.
REQ-038 n_start=0xFFFFFFFF, n_count=2 -> indices 0xFFFFFFFF then 0x00000000.
REQ-039 n_count=0 -> no out_valid, done one cycle after start, busy never high.
REQ-040 abort at beat 5 of an n_count=3 run -> out_valid low next cycle, IDLE, no done; a new start=1 with n_start=7 then produces index 7, dim 0 first.
REQ-041 rst pulsed mid-run and start pulsed while busy -> all outputs at reset values, and the ignored start does not perturb the sequence.

Source files
------------

// File: rtl/sobol_pkg.sv
// sobol_pkg: shared FSM states, default dimension count and Sobol direction-number tables.
package sobol_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;
  localparam int M_DEF = 12;
  localparam int TAB_N = 12;
  localparam int S_TAB [TAB_N] = '{0, 1, 2, 3, 3, 4, 4, 5, 5, 5, 5, 5};
  localparam int A_TAB [TAB_N] = '{0, 0, 1, 1, 2, 1, 4, 2, 4, 7, 11, 13};
  localparam int M_TAB [TAB_N][5] = '{
    '{1, 1, 1, 1, 1}, '{1, 0, 0, 0, 0}, '{1, 3, 0, 0, 0}, '{1, 3, 1, 0, 0},
    '{1, 1, 1, 0, 0}, '{1, 1, 3, 3, 0}, '{1, 3, 5, 13, 0}, '{1, 1, 5, 5, 17},
    '{1, 1, 5, 5, 5}, '{1, 1, 7, 11, 19}, '{1, 1, 5, 1, 1}, '{1, 1, 1, 3, 11}};
  // Direction numbers V_1..V_32 of dimension d, packed with V_k at slice k-1.
  function automatic logic [1023:0] dir_vec(input int d);
    logic [31:0] m [33];
    logic [1023:0] r;
    int s;
    int a;
    r = '0;
    m = '{default: '0};
    s = S_TAB[d];
    a = A_TAB[d];
    for (int k = 1; k <= 32; k++) begin
      if (d == 0) m[k] = 32'd1;
      else if (k <= s) m[k] = M_TAB[d][k-1];
      else begin
        m[k] = m[k-s] ^ (m[k-s] << s);
        for (int j = 1; j < s; j++)
          if (((a >> (s - 1 - j)) & 1) != 0) m[k] = m[k] ^ (m[k-j] << j);
      end
      r[(k-1)*32 +: 32] = m[k] << (32 - k);
    end
    return r;
  endfunction
endpackage

// File: rtl/sobol.sv
// sobol: combinational Sobol value for index idx_i in dimension dim_i.
module sobol
  import sobol_pkg::*;
#(
  parameter int M = M_DEF,
  localparam int DIM_W = $clog2(M)
) (
  input  logic [31:0]      idx_i,
  input  logic [DIM_W-1:0] dim_i,
  output logic [31:0]      data_o
);
  logic [1023:0] tbl [M];
  logic [1023:0] v;
  for (genvar g = 0; g < M; g++) begin : g_tbl
    assign tbl[g] = dir_vec(g % TAB_N);
  end
  always_comb begin
    v = tbl[dim_i];
    data_o = '0;
    for (int k = 0; k < 32; k++) data_o = idx_i[k] ? data_o ^ v[k*32 +: 32] : data_o;
  end
endmodule

// File: rtl/sobol_sequencer.sv
// sobol_sequencer: streams n_count Sobol points of M dimensions each over a valid/ready port.
module sobol_sequencer
  import sobol_pkg::*;
#(
  parameter int M = M_DEF,
  localparam int DIM_W = $clog2(M)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      n_start,
  input  logic [31:0]      n_count,
  output logic             busy,
  output logic             done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [31:0]      out_index,
  output logic [DIM_W-1:0] out_dim,
  output logic             out_last
);
  state_e state_q, state_d;
  logic [31:0] idx_q, idx_d, rem_q, rem_d, data_q, data_d, index_q, index_d, gen;
  logic [DIM_W-1:0] dim_q, dim_d, odim_q, odim_d;
  logic valid_q, valid_d, last_q, last_d, load, wrap;
  sobol #(.M(M)) u_gen (.idx_i(idx_q), .dim_i(dim_q), .data_o(gen));
  assign load = !valid_q || out_ready;
  assign wrap = dim_q == DIM_W'(M - 1);
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    dim_d = dim_q;
    rem_d = rem_q;
    valid_d = valid_q;
    last_d = last_q;
    data_d = data_q;
    index_d = index_q;
    odim_d = odim_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = n_count != 0 ? RUN : DONE;
        idx_d = n_count != 0 ? n_start : idx_q;
        dim_d = n_count != 0 ? '0 : dim_q;
        rem_d = n_count != 0 ? n_count : rem_q;
      end
      RUN: if (load) begin
        valid_d = 1'b1;
        data_d = gen;
        index_d = idx_q;
        odim_d = dim_q;
        last_d = wrap && rem_q == 32'd1;
        dim_d = wrap ? '0 : dim_q + DIM_W'(1);
        idx_d = wrap ? idx_q + 32'd1 : idx_q;
        rem_d = wrap ? rem_q - 32'd1 : rem_q;
        state_d = wrap && rem_q == 32'd1 ? FLUSH : RUN;
      end
      FLUSH: if (valid_q && out_ready) begin
        valid_d = 1'b0;
        last_d = 1'b0;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      valid_d = 1'b0;
      last_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      dim_q <= '0;
      rem_q <= '0;
      valid_q <= 1'b0;
      last_q <= 1'b0;
      data_q <= '0;
      index_q <= '0;
      odim_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      dim_q <= dim_d;
      rem_q <= rem_d;
      valid_q <= valid_d;
      last_q <= last_d;
      data_q <= data_d;
      index_q <= index_d;
      odim_q <= odim_d;
    end
  end
  assign busy = state_q == RUN || state_q == FLUSH;
  assign done = state_q == DONE && !abort;
  assign out_valid = valid_q;
  assign out_last = last_q;
  assign out_data = data_q;
  assign out_index = index_q;
  assign out_dim = odim_q;
endmodule

// File: tb/tb_sobol_sequencer.sv
// tb_sobol_sequencer: directed and random runs checked against a textbook Sobol reference.
module tb_sobol_sequencer;
  localparam int M = 12;
  logic clk = 1'b0;
  logic rst, start, abort, out_ready, busy, done, out_valid, out_last;
  logic [31:0] n_start, n_count, out_data, out_index;
  logic [3:0] out_dim;
  int tests = 0;
  int fails = 0;
  logic [31:0] vt [12][32];
  int s_t [12] = '{0, 1, 2, 3, 3, 4, 4, 5, 5, 5, 5, 5};
  int a_t [12] = '{0, 0, 1, 1, 2, 1, 4, 2, 4, 7, 11, 13};
  int mi_t [12][5] = '{
    '{1, 1, 1, 1, 1}, '{1, 0, 0, 0, 0}, '{1, 3, 0, 0, 0}, '{1, 3, 1, 0, 0},
    '{1, 1, 1, 0, 0}, '{1, 1, 3, 3, 0}, '{1, 3, 5, 13, 0}, '{1, 1, 5, 5, 17},
    '{1, 1, 5, 5, 5}, '{1, 1, 7, 11, 19}, '{1, 1, 5, 1, 1}, '{1, 1, 1, 3, 11}};

  always #5 clk = ~clk;

  sobol_sequencer #(.M(M)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .n_start(n_start), .n_count(n_count),
    .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_dim(out_dim), .out_last(out_last));

  // Fixed-point direction numbers via the Bratley-Fox recurrence on V directly.
  function automatic void build_dirs();
    logic [31:0] v;
    for (int d = 0; d < 12; d++)
      for (int k = 0; k < 32; k++) begin
        if (d == 0) vt[d][k] = 32'h8000_0000 >> k;
        else if (k < s_t[d]) vt[d][k] = 32'(mi_t[d][k]) << (31 - k);
        else begin
          v = vt[d][k-s_t[d]] ^ (vt[d][k-s_t[d]] >> s_t[d]);
          for (int j = 1; j < s_t[d]; j++)
            if (((a_t[d] >> (s_t[d] - 1 - j)) & 1) != 0) v = v ^ vt[d][k-j];
          vt[d][k] = v;
        end
      end
  endfunction

  function automatic logic [31:0] ref_val(input logic [31:0] n, input int d);
    logic [31:0] x = '0;
    for (int k = 0; k < 32; k++) if (n[k]) x = x ^ vt[d][k];
    return x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_last"}, 32'(out_last), 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_index"}, out_index, 0);
    chk({tag, "_dim"}, 32'(out_dim), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
  endtask

  // mode: 0 ready high, 1 ready pattern 1,0,0,1, 2 random ready; ign pulses start mid-run.
  task automatic run(input logic [31:0] ns, input logic [31:0] nc, input int mode,
                     input int abort_at, input int rst_at, input bit ign);
    int total, beat, cyc;
    bit stall;
    logic [31:0] pd, pi;
    logic [3:0] pdim;
    logic pl;
    total = int'(nc) * M;
    beat = 0;
    cyc = 0;
    stall = 0;
    @(negedge clk);
    start = 1; n_start = ns; n_count = nc; out_ready = 1;
    @(negedge clk);
    start = 0; n_start = $urandom; n_count = $urandom;
    chk("start_valid", 32'(out_valid), 0);
    if (nc == 0) begin
      chk("zero_done", 32'(done), 1);
      chk("zero_busy", 32'(busy), 0);
      @(negedge clk);
      chk("zero_done_drop", 32'(done), 0);
      chk("zero_valid", 32'(out_valid), 0);
      chk("zero_busy2", 32'(busy), 0);
      return;
    end
    chk("start_busy", 32'(busy), 1);
    while (beat < total && cyc < total * 8 + 20) begin
      @(negedge clk);
      cyc++;
      if (stall) begin
        chk("stall_valid", 32'(out_valid), 1);
        chk("stall_data", out_data, pd);
        chk("stall_index", out_index, pi);
        chk("stall_dim", 32'(out_dim), 32'(pdim));
        chk("stall_last", 32'(out_last), 32'(pl));
      end
      if (beat == abort_at) begin
        abort = 1; out_ready = 0;
        @(negedge clk);
        abort = 0;
        chk("abort_valid", 32'(out_valid), 0);
        chk("abort_last", 32'(out_last), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        @(negedge clk);
        chk("abort_done2", 32'(done), 0);
        return;
      end
      if (beat == rst_at) begin
        rst = 1; start = 1; n_count = 4;
        @(negedge clk);
        rst = 0; start = 0;
        chk_reset_outputs("midrst");
        @(negedge clk);
        chk("midrst_busy2", 32'(busy), 0);
        chk("midrst_done2", 32'(done), 0);
        return;
      end
      start = ign && cyc == 3;
      if (start) begin n_start = 32'h1234; n_count = 5; end
      out_ready = mode == 0 ? 1'b1 : mode == 1 ? ((cyc - 1) % 4 == 0 || (cyc - 1) % 4 == 3)
                : 1'($urandom_range(0, 1));
      chk("run_busy", 32'(busy), 1);
      if (out_valid && out_ready) begin
        chk("beat_data", out_data, ref_val(ns + 32'(beat / M), beat % M));
        chk("beat_index", out_index, ns + 32'(beat / M));
        chk("beat_dim", 32'(out_dim), 32'(beat % M));
        chk("beat_last", 32'(out_last), 32'(beat == total - 1));
        beat++;
      end
      stall = out_valid && !out_ready;
      pd = out_data; pi = out_index; pdim = out_dim; pl = out_last;
    end
    start = 0;
    chk("beat_count", 32'(beat), 32'(total));
    if (mode == 0) chk("throughput_cycles", 32'(cyc), 32'(total));
    @(negedge clk);
    chk("end_done", 32'(done), 1);
    chk("end_valid", 32'(out_valid), 0);
    chk("end_busy", 32'(busy), 0);
    @(negedge clk);
    chk("end_done_drop", 32'(done), 0);
  endtask

  initial begin
    build_dirs();
    rst = 1; start = 0; abort = 0; out_ready = 0; n_start = 0; n_count = 0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 0;
    run(32'd10, 32'd2, 0, -1, -1, 0);
    run(32'd10, 32'd2, 1, -1, -1, 0);
    run(32'hFFFF_FFFF, 32'd2, 0, -1, -1, 0);
    run(32'd0, 32'd0, 0, -1, -1, 0);
    run(32'd100, 32'd3, 0, 5, -1, 0);
    run(32'd7, 32'd1, 0, -1, -1, 0);
    run(32'd50, 32'd3, 2, -1, 13, 1);
    run(32'd20, 32'd2, 2, -1, -1, 1);
    @(negedge clk);
    abort = 1; start = 1; n_start = 32'd3; n_count = 32'd2;
    @(negedge clk);
    abort = 0; start = 0;
    chk("abort_start_busy", 32'(busy), 0);
    chk("abort_start_valid", 32'(out_valid), 0);
    @(negedge clk);
    chk("abort_start_busy2", 32'(busy), 0);
    chk("abort_start_done", 32'(done), 0);
    repeat (4) run($urandom, 32'($urandom_range(1, 3)), 2, -1, -1, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
